// File: rtl/reg_file_pkg.sv
// Shared widths, address/data types and the live-register predicate for the register file.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam int unsigned ZERO_REG = 0;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;

    // True for an index that names real, writable storage (not x0, not past the array).
    function automatic logic reg_live(input int unsigned idx, input int unsigned nregs);
        return (idx != ZERO_REG) && (idx < nregs);
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, issue sets, writeback clears.
// Latency: set/clear visible after the clock edge; with BYPASS a completing write hides busy in-cycle.
// Backpressure: none; every issue/clear strobe is accepted in the cycle presented.
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] lk1_addr,
    input  logic [AW-1:0] lk2_addr,
    output logic          lk1_busy,
    output logic          lk2_busy
);
    import reg_file_pkg::*;

    logic [NREGS-1:0] busy;
    logic             set_hit;
    logic             clr_hit;
    logic             lk1_fwd_clr;
    logic             lk2_fwd_clr;

    assign set_hit = set_en && reg_live(32'(set_addr), NREGS);
    assign clr_hit = clr_en && reg_live(32'(clr_addr), NREGS);

    // The set is written last so a same-index issue and writeback leaves the new producer pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_hit) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_hit) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    assign lk1_fwd_clr = BYPASS && clr_en && (clr_addr == lk1_addr);
    assign lk2_fwd_clr = BYPASS && clr_en && (clr_addr == lk2_addr);

    always_comb begin
        lk1_busy = 1'b0;
        lk2_busy = 1'b0;
        if (reg_live(32'(lk1_addr), NREGS)) begin
            lk1_busy = busy[lk1_addr] && !lk1_fwd_clr;
        end
        if (reg_live(32'(lk2_addr), NREGS)) begin
            lk2_busy = busy[lk2_addr] && !lk2_fwd_clr;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a busy scoreboard.
// Latency: reads zero-cycle; writes visible after the edge (same cycle on the read ports with BYPASS).
// Backpressure: none; writeback and issue are accepted unconditionally.
module reg_file_sb #(
    parameter int NREGS  = 32,
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd
);
    import reg_file_pkg::*;

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_hit;
    logic            rs1_fwd;
    logic            rs2_fwd;

    assign wr_hit = wr_en && reg_live(32'(wr_addr), NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Forwarding is held off during reset so every read port reports zero while rst_n is low.
    assign rs1_fwd = BYPASS && rst_n && wr_en && (wr_addr == rs1_addr);
    assign rs2_fwd = BYPASS && rst_n && wr_en && (wr_addr == rs2_addr);

    always_comb begin
        rs1_data = '0;
        if (reg_live(32'(rs1_addr), NREGS)) begin
            rs1_data = rs1_fwd ? wr_data : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (reg_live(32'(rs2_addr), NREGS)) begin
            rs2_data = rs2_fwd ? wr_data : regs[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_en),
        .set_addr (issue_rd),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .lk1_addr (rs1_addr),
        .lk2_addr (rs2_addr),
        .lk1_busy (rs1_busy),
        .lk2_busy (rs2_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share stimulus and are
// compared every cycle against an array model, plus directed literal checks.
`timescale 1ns/100ps
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [31:0] wr_data;
    logic        wr_en, issue_en;

    logic [31:0] d1_rs1_data, d1_rs2_data, d0_rs1_data, d0_rs2_data;
    logic        d1_rs1_busy, d1_rs2_busy, d0_rs1_busy, d0_rs2_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32] = '{default: 32'h0};
    bit          m_busy [32] = '{default: 1'b0};

    reg_file_sb #(.NREGS(32), .XLEN(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d1_rs1_data), .rs2_data(d1_rs2_data),
        .rs1_busy(d1_rs1_busy), .rs2_busy(d1_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd)
    );

    reg_file_sb #(.NREGS(32), .XLEN(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d0_rs1_data), .rs2_data(d0_rs2_data),
        .rs1_busy(d0_rs1_busy), .rs2_busy(d0_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state: the last value written to each register, and whether an issued
    // instruction still owes it a write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 5'd0) begin
                m_busy[issue_rd] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 1'b0;
        if (byp && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        chk($sformatf("byp_rs1_data[%0d]", rs1_addr), d1_rs1_data, exp_data(rs1_addr, 1'b1));
        chk($sformatf("byp_rs2_data[%0d]", rs2_addr), d1_rs2_data, exp_data(rs2_addr, 1'b1));
        chk($sformatf("byp_rs1_busy[%0d]", rs1_addr), 32'(d1_rs1_busy), 32'(exp_busy(rs1_addr, 1'b1)));
        chk($sformatf("byp_rs2_busy[%0d]", rs2_addr), 32'(d1_rs2_busy), 32'(exp_busy(rs2_addr, 1'b1)));
        chk($sformatf("nb_rs1_data[%0d]", rs1_addr), d0_rs1_data, exp_data(rs1_addr, 1'b0));
        chk($sformatf("nb_rs2_data[%0d]", rs2_addr), d0_rs2_data, exp_data(rs2_addr, 1'b0));
        chk($sformatf("nb_rs1_busy[%0d]", rs1_addr), 32'(d0_rs1_busy), 32'(exp_busy(rs1_addr, 1'b0)));
        chk($sformatf("nb_rs2_busy[%0d]", rs2_addr), 32'(d0_rs2_busy), 32'(exp_busy(rs2_addr, 1'b0)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; issue_rd = '0;
        wr_data = '0; wr_en = 1'b0; issue_en = 1'b0;

        // Held in reset with write and issue strobes active: everything must read zero.
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(a) ^ 5'h1f;
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = $urandom;
            issue_en = 1'b1; issue_rd = 5'(a);
            #1;
            chk("rst_rs1_data", d1_rs1_data, 32'h0);
            chk("rst_rs2_data", d1_rs2_data, 32'h0);
            chk("rst_rs1_busy", 32'(d1_rs1_busy), 32'h0);
            chk("rst_rs2_busy", 32'(d0_rs2_busy), 32'h0);
        end
        idle();
        step();
        rst_n = 1'b1;
        rs1_addr = 5'd5;
        #1;
        chk("post_rst_reg5", d1_rs1_data, 32'h0);

        step();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk("byp_wr5_same_cycle", d1_rs1_data, 32'hDEADBEEF);
        chk("nb_wr5_same_cycle", d0_rs1_data, 32'h0);
        step();
        idle();
        #1;
        chk("byp_rd5_rs1", d1_rs1_data, 32'hDEADBEEF);
        chk("byp_rd5_rs2", d1_rs2_data, 32'hDEADBEEF);
        chk("nb_rd5_rs1", d0_rs1_data, 32'hDEADBEEF);
        chk("nb_rd5_rs2", d0_rs2_data, 32'hDEADBEEF);

        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        chk("x0_write_bypass", d1_rs1_data, 32'h0);
        step();
        idle();
        #1;
        chk("x0_read_byp", d1_rs1_data, 32'h0);
        chk("x0_read_nb", d0_rs2_data, 32'h0);

        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs1_addr = 5'd7;
        #1;
        chk("bypass7_byp", d1_rs1_data, 32'hA5A5A5A5);
        chk("bypass7_nb_old", d0_rs1_data, 32'h0);
        step();
        idle();
        #1;
        chk("bypass7_nb_after", d0_rs1_data, 32'hA5A5A5A5);

        step();
        issue_en = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
        #1;
        chk("sb3_cycle0", 32'(d1_rs1_busy), 32'h0);
        step();
        idle();
        #1;
        chk("sb3_cycle1_byp", 32'(d1_rs1_busy), 32'h1);
        chk("sb3_cycle1_nb", 32'(d0_rs1_busy), 32'h1);
        step();
        step();
        chk("sb3_cycle3", 32'(d1_rs1_busy), 32'h1);
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        chk("sb3_wb_byp_clear", 32'(d1_rs1_busy), 32'h0);
        chk("sb3_wb_nb_still", 32'(d0_rs1_busy), 32'h1);
        chk("sb3_wb_data", d1_rs1_data, 32'h33);
        step();
        idle();
        #1;
        chk("sb3_cycle5_byp", 32'(d1_rs1_busy), 32'h0);
        chk("sb3_cycle5_nb", 32'(d0_rs1_busy), 32'h0);

        step();
        issue_en = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        step();
        idle();
        #1;
        chk("issue_x0_busy", 32'(d1_rs1_busy), 32'h0);

        step();
        issue_en = 1'b1; issue_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99999999;
        rs1_addr = 5'd9;
        step();
        idle();
        #1;
        chk("iw9_data", d0_rs1_data, 32'h99999999);
        chk("iw9_busy_byp", 32'(d1_rs1_busy), 32'h1);
        chk("iw9_busy_nb", 32'(d0_rs1_busy), 32'h1);

        step();
        issue_en = 1'b1; issue_rd = 5'd10;
        step();
        issue_en = 1'b1; issue_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0A;
        rs1_addr = 5'd9; rs2_addr = 5'd10;
        step();
        idle();
        #1;
        chk("i9w10_busy9", 32'(d1_rs1_busy), 32'h1);
        chk("i9w10_busy10", 32'(d0_rs2_busy), 32'h0);
        chk("i9w10_data10", d0_rs2_data, 32'h0A);

        step();
        issue_en = 1'b1; issue_rd = 5'd3; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1;
        step();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd5;
        #1;
        chk("pre_rst_busy3", 32'(d0_rs1_busy), 32'h1);
        chk("pre_rst_reg5", d0_rs2_data, 32'h1);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF;
        #1;
        chk("mid_rst_busy3", 32'(d1_rs1_busy), 32'h0);
        chk("mid_rst_reg5_byp", d1_rs2_data, 32'h0);
        chk("mid_rst_reg5_nb", d0_rs2_data, 32'h0);
        step();
        rst_n = 1'b1;
        idle();
        #1;
        chk("after_rst_reg5_byp", d1_rs2_data, 32'h0);
        chk("after_rst_reg5_nb", d0_rs2_data, 32'h0);
        chk("after_rst_busy3", 32'(d0_rs1_busy), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = pick();
            wr_data  = $urandom;
            issue_en = ($urandom_range(0, 2) != 0);
            issue_rd = pick();
            rs1_addr = pick();
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : pick();
        end
        step();
        idle();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
